// File: rtl/sound_sequencer_pkg.sv
// Shared types, melody table and helpers for the Pacman sound sequencer.
package sound_pkg;

  typedef struct packed {
    logic [1:0] note;
    logic       rest;
    logic [3:0] dur;
  } step_t;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } state_t;

  localparam logic [1:0] SND_DEATH = 2'd0;
  localparam logic [1:0] SND_GHOST = 2'd1;
  localparam logic [1:0] SND_DOT   = 2'd2;
  localparam logic [1:0] SND_START = 2'd3;

  // Indexed [requester][step]
  localparam step_t MELODY_ROM [4][4] = '{
    '{'{2'd3, 1'b0, 4'd4}, '{2'd2, 1'b0, 4'd4}, '{2'd1, 1'b0, 4'd4}, '{2'd0, 1'b0, 4'd8}},
    '{'{2'd0, 1'b0, 4'd2}, '{2'd1, 1'b0, 4'd2}, '{2'd0, 1'b0, 4'd2}, '{2'd1, 1'b0, 4'd2}},
    '{'{2'd0, 1'b0, 4'd1}, '{2'd0, 1'b1, 4'd1}, '{2'd0, 1'b0, 4'd1}, '{2'd0, 1'b1, 4'd1}},
    '{'{2'd2, 1'b0, 4'd3}, '{2'd2, 1'b0, 4'd3}, '{2'd1, 1'b0, 4'd3}, '{2'd0, 1'b0, 4'd6}}
  };

  // Index of the lowest set bit, i.e. the highest-priority requester.
  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    lowest_set = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) lowest_set = 2'(i);
    end
  endfunction

endpackage

// File: rtl/sound_sequencer_if.sv
// Request/tone bus between game logic (master) and the sound sequencer (slave).
interface sound_sequencer_if;
  logic [3:0] req;
  logic [1:0] num;
  logic       pressed;
  logic       busy;
  logic [1:0] active_id;
  logic       done;

  modport master (output req, input num, pressed, busy, active_id, done);
  modport slave  (input req, output num, pressed, busy, active_id, done);
endinterface

// File: rtl/sound_sequencer_tick_gen.sv
// Duration prescaler: one-cycle tick every TICK_DIV cycles, restarted by clear.
module sound_tick_gen #(
  parameter int unsigned TICK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CntW-1:0] r_cnt;

  assign tick = (r_cnt == CntW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end
endmodule

// File: rtl/sound_sequencer.sv
// Fixed-priority sound request arbiter that plays a short melody into the tone datapath.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1_000_000,
  parameter int unsigned NREQ     = 4,
  parameter int unsigned STEPS    = 4
) (
  input logic               clk,
  input logic               rst,
  sound_sequencer_if.slave  bus
);
  localparam int unsigned StepW = $clog2(STEPS);

  state_t            r_state, w_state_d;
  logic [NREQ-1:0]   r_pending, w_pending_d, w_grant_mask, w_higher;
  logic [1:0]        r_active, w_active_d, w_grant_id;
  logic [StepW-1:0]  r_step, w_step_d;
  logic [3:0]        r_dur_cnt, w_dur_cnt_d, w_dur_eff;
  logic [1:0]        r_num, w_num_d;
  logic              r_pressed, w_pressed_d, r_busy, w_busy_d, r_done, w_done_d;
  logic              w_tick, w_start, w_clear;
  step_t             w_cur, w_nxt;

  // Counter restarts on every melody start and stays parked while idle.
  assign w_clear = w_start || (r_state == IDLE);

  sound_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clear(w_clear),
    .tick (w_tick)
  );

  always_comb begin
    w_grant_id   = lowest_set(r_pending);
    w_higher     = (NREQ'(1) << r_active) - NREQ'(1);
    w_start      = (r_state == IDLE) ? |r_pending : |(r_pending & w_higher);
    w_cur        = MELODY_ROM[r_active][r_step];
    w_dur_eff    = (w_cur.dur == 4'd0) ? 4'd1 : w_cur.dur;
    w_nxt        = w_cur;
    w_state_d    = r_state;
    w_active_d   = r_active;
    w_step_d     = r_step;
    w_dur_cnt_d  = r_dur_cnt;
    w_num_d      = r_num;
    w_pressed_d  = r_pressed;
    w_busy_d     = r_busy;
    w_done_d     = 1'b0;
    w_grant_mask = '0;

    if (w_start) begin
      w_state_d                = PLAY;
      w_active_d               = w_grant_id;
      w_step_d                 = '0;
      w_dur_cnt_d              = '0;
      w_busy_d                 = 1'b1;
      w_grant_mask[w_grant_id] = 1'b1;
    end else begin
      unique case (r_state)
        PLAY: begin
          if (w_tick) begin
            if ({1'b0, r_dur_cnt} + 5'd1 >= {1'b0, w_dur_eff}) begin
              w_state_d   = GAP;
              w_dur_cnt_d = '0;
            end else begin
              w_dur_cnt_d = r_dur_cnt + 4'd1;
            end
          end
        end
        GAP: begin
          if (w_tick) begin
            if (r_step == StepW'(STEPS - 1)) begin
              w_state_d = IDLE;
              w_busy_d  = 1'b0;
              w_done_d  = 1'b1;
            end else begin
              w_state_d = PLAY;
              w_step_d  = r_step + StepW'(1);
            end
          end
        end
        default: ;
      endcase
    end

    // Outputs are registered from the next state so they align with it.
    if (w_state_d == PLAY) begin
      w_nxt       = MELODY_ROM[w_active_d][w_step_d];
      w_num_d     = w_nxt.note;
      w_pressed_d = ~w_nxt.rest;
    end else begin
      w_pressed_d = 1'b0;
    end

    // A new request in the grant cycle survives the clear.
    w_pending_d = (r_pending & ~w_grant_mask) | bus.req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_active  <= '0;
      r_step    <= '0;
      r_dur_cnt <= '0;
      r_num     <= '0;
      r_pressed <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_pending <= w_pending_d;
      r_active  <= w_active_d;
      r_step    <= w_step_d;
      r_dur_cnt <= w_dur_cnt_d;
      r_num     <= w_num_d;
      r_pressed <= w_pressed_d;
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;
    end
  end

  assign bus.num       = r_num;
  assign bus.pressed   = r_pressed;
  assign bus.busy      = r_busy;
  assign bus.active_id = r_active;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_sound_sequencer.sv
// Self-checking bench for sound_sequencer with TICK_DIV=4.
module tb_sound_sequencer;
  import sound_pkg::*;

  localparam int unsigned TD = 4;

  typedef struct {
    int         k;
    logic [1:0] num;
    logic       pressed;
    logic       busy;
    logic [1:0] id;
    logic       done;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sound_sequencer_if bus();

  sound_sequencer #(
    .TICK_DIV(TD),
    .NREQ    (4),
    .STEPS   (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         done_cnt = 0;
  logic [1:0] start_q[$];
  logic [1:0] ghost_notes[$];
  logic       prev_busy = 1'b0;
  logic       prev_pressed = 1'b0;
  logic [1:0] prev_id = 2'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every observed melody start is matched against the queue of expected starts.
  task automatic monitor();
    if (bus.busy && (!prev_busy || bus.active_id != prev_id)) begin
      if (start_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_start: got id %0d, expected no start", bus.active_id);
      end else begin
        chk("start_id", 32'(bus.active_id), 32'(start_q.pop_front()));
      end
    end
    if (bus.done) done_cnt++;
    if (bus.pressed && !prev_pressed && bus.active_id == SND_GHOST)
      ghost_notes.push_back(bus.num);
    prev_busy    = bus.busy;
    prev_id      = bus.active_id;
    prev_pressed = bus.pressed;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic pulse(input logic [3:0] r);
    bus.req = r;
    cyc();
    bus.req = 4'b0000;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      cyc();
      if (bus.done) seen = 1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got no done within %0d cycles, expected a done pulse", name, budget);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_num"}, 32'(bus.num), 32'd0);
    chk({name, "_pressed"}, 32'(bus.pressed), 32'd0);
    chk({name, "_busy"}, 32'(bus.busy), 32'd0);
    chk({name, "_id"}, 32'(bus.active_id), 32'd0);
    chk({name, "_done"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[$];
    logic [1:0] exp_g[4];
    int         k;
    bit         seen;
    bit         any_busy;

    // Dot melody, durations 1 tick (4 cycles): note, gap, rest, gap, note, gap, rest, gap.
    tbl.push_back('{1,  2'd0, 1'b1, 1'b1, 2'd2, 1'b0});
    tbl.push_back('{4,  2'd0, 1'b1, 1'b1, 2'd2, 1'b0});
    tbl.push_back('{5,  2'd0, 1'b0, 1'b1, 2'd2, 1'b0});
    tbl.push_back('{8,  2'd0, 1'b0, 1'b1, 2'd2, 1'b0});
    tbl.push_back('{9,  2'd0, 1'b0, 1'b1, 2'd2, 1'b0});
    tbl.push_back('{13, 2'd0, 1'b0, 1'b1, 2'd2, 1'b0});
    tbl.push_back('{17, 2'd0, 1'b1, 1'b1, 2'd2, 1'b0});
    tbl.push_back('{20, 2'd0, 1'b1, 1'b1, 2'd2, 1'b0});
    tbl.push_back('{21, 2'd0, 1'b0, 1'b1, 2'd2, 1'b0});
    tbl.push_back('{25, 2'd0, 1'b0, 1'b1, 2'd2, 1'b0});
    tbl.push_back('{32, 2'd0, 1'b0, 1'b1, 2'd2, 1'b0});
    tbl.push_back('{33, 2'd0, 1'b0, 1'b0, 2'd2, 1'b1});
    tbl.push_back('{34, 2'd0, 1'b0, 1'b0, 2'd2, 1'b0});

    // Reset state
    bus.req = 4'b0000;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    cyc();

    // 1: single dot request
    done_cnt = 0;
    start_q.push_back(SND_DOT);
    pulse(4'b0100);
    k = 0;
    foreach (tbl[v]) begin
      while (k < tbl[v].k) begin
        cyc();
        k++;
      end
      chk($sformatf("t1_k%0d_num", k), 32'(bus.num), 32'(tbl[v].num));
      chk($sformatf("t1_k%0d_pressed", k), 32'(bus.pressed), 32'(tbl[v].pressed));
      chk($sformatf("t1_k%0d_busy", k), 32'(bus.busy), 32'(tbl[v].busy));
      chk($sformatf("t1_k%0d_done", k), 32'(bus.done), 32'(tbl[v].done));
      if (tbl[v].busy) chk($sformatf("t1_k%0d_id", k), 32'(bus.active_id), 32'(tbl[v].id));
    end
    repeat (4) cyc();
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);

    // 2: simultaneous ghost + start requests
    done_cnt = 0;
    start_q.push_back(SND_GHOST);
    start_q.push_back(SND_START);
    pulse(4'b1010);
    wait_done("t2_first_done", 200);
    chk("t2_gap_busy", 32'(bus.busy), 32'd0);
    chk("t2_gap_pressed", 32'(bus.pressed), 32'd0);
    cyc();
    chk("t2_second_busy", 32'(bus.busy), 32'd1);
    chk("t2_second_id", 32'(bus.active_id), 32'(SND_START));
    chk("t2_second_num", 32'(bus.num), 32'd2);
    chk("t2_second_pressed", 32'(bus.pressed), 32'd1);
    wait_done("t2_second_done", 200);
    repeat (5) cyc();
    chk("t2_done_cnt", 32'(done_cnt), 32'd2);
    chk("t2_starts_left", 32'(start_q.size()), 32'd0);

    // 3: death preempts start melody during step 2
    done_cnt = 0;
    start_q.push_back(SND_START);
    pulse(4'b1000);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      cyc();
      if (bus.busy && bus.pressed && bus.num == 2'd1) seen = 1;
    end
    chk("t3_reached_step2", 32'(seen), 32'd1);
    start_q.push_back(SND_DEATH);
    pulse(4'b0001);
    cyc();
    chk("t3_pre_id", 32'(bus.active_id), 32'(SND_DEATH));
    chk("t3_pre_num", 32'(bus.num), 32'd3);
    chk("t3_pre_pressed", 32'(bus.pressed), 32'd1);
    chk("t3_pre_busy", 32'(bus.busy), 32'd1);
    wait_done("t3_death_done", 300);
    repeat (100) cyc();
    chk("t3_done_cnt", 32'(done_cnt), 32'd1);
    chk("t3_idle_busy", 32'(bus.busy), 32'd0);
    chk("t3_starts_left", 32'(start_q.size()), 32'd0);

    // 4: dot request waits behind ghost, ghost plays all notes
    done_cnt = 0;
    ghost_notes.delete();
    exp_g[0] = 2'd0; exp_g[1] = 2'd1; exp_g[2] = 2'd0; exp_g[3] = 2'd1;
    start_q.push_back(SND_GHOST);
    start_q.push_back(SND_DOT);
    pulse(4'b0010);
    repeat (10) cyc();
    pulse(4'b0100);
    wait_done("t4_ghost_done", 200);
    chk("t4_ghost_notes", 32'(ghost_notes.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < ghost_notes.size())
        chk($sformatf("t4_ghost_note%0d", i), 32'(ghost_notes[i]), 32'(exp_g[i]));
    end
    cyc();
    chk("t4_dot_id", 32'(bus.active_id), 32'(SND_DOT));
    chk("t4_dot_busy", 32'(bus.busy), 32'd1);
    wait_done("t4_dot_done", 200);
    chk("t4_done_cnt", 32'(done_cnt), 32'd2);
    chk("t4_starts_left", 32'(start_q.size()), 32'd0);

    // 5: asynchronous reset in the middle of death step 1
    start_q.push_back(SND_DEATH);
    pulse(4'b0001);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      cyc();
      if (bus.busy && bus.num == 2'd2) seen = 1;
    end
    chk("t5_reached_step1", 32'(seen), 32'd1);
    repeat (3) cyc();
    rst = 1'b1;
    #1;
    chk_zero("t5_async");
    cyc();
    rst = 1'b0;
    done_cnt = 0;
    any_busy = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (bus.busy) any_busy = 1;
    end
    chk("t5_stays_idle", 32'(any_busy), 32'd0);
    chk("t5_no_done", 32'(done_cnt), 32'd0);

    // 6: ghost re-requested while playing replays exactly once
    done_cnt = 0;
    start_q.push_back(SND_GHOST);
    start_q.push_back(SND_GHOST);
    pulse(4'b0010);
    repeat (5) cyc();
    bus.req = 4'b0010;
    repeat (3) cyc();
    bus.req = 4'b0000;
    wait_done("t6_first_done", 200);
    wait_done("t6_second_done", 200);
    repeat (80) cyc();
    chk("t6_done_cnt", 32'(done_cnt), 32'd2);
    chk("t6_starts_left", 32'(start_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sound_sequencer.md
Name: sound_sequencer

Overview:
- Controller for the Pacman tone datapath, which maps a 2-bit note number plus a "pressed" flag to a square-wave frequency.
- Accepts one-shot sound requests from game logic: 0=death, 1=eat-ghost, 2=eat-dot, 3=start-jingle.
- Arbitrates by fixed priority and plays a short fixed melody for the granted request.
- Drives num/pressed into the tone datapath, so only one melody ever owns the speaker.

Parameters:
- TICK_DIV, 1_000_000, clk cycles per duration tick (10 ms at 100 MHz); legal 2..2^24.
- NREQ, 4, number of requesters; fixed at 4 in this revision.
- STEPS, 4, steps per melody.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req  in  4  request pulses, one bit per requester; level is sampled every cycle
- num  out  2  note number to the tone datapath
- pressed  out  1  tone enable to the tone datapath; 0 gives the silent/idle frequency
- busy  out  1  melody in progress
- active_id  out  2  requester currently playing; valid while busy
- done  out  1  one-cycle pulse when a melody completes normally

Behaviour:
- Reset (async, rst=1): num=0, pressed=0, busy=0, active_id=0, done=0, pending=0, state=IDLE, step=0, tick counter=0, duration counter=0.
- All outputs are registered.
- Pending register (4 bits):
  - Any cycle with req[i]=1 sets pending[i].
  - A bit clears when its requester is granted.
  - Set and clear in the same cycle: set wins.
- Arbitration: fixed priority, lowest index highest.
- IDLE:
  - If pending≠0, grant the lowest set bit i and go to PLAY with step=0, active_id=i, busy=1.
  - Tick counter and duration counter restart at 0.
  - A req at edge t sets pending at t; outputs reflect step 0 after edge t+1.
- Tick generator: tick pulses for 1 cycle every TICK_DIV cycles, counted from melody start. It is held at 0 while IDLE.
- PLAY:
  - num = ROM[i][step].note.
  - pressed = !ROM[i][step].rest.
  - On each tick, the duration counter increments. When it reaches dur (dur=0 treated as 1), go to GAP.
- GAP (note separation):
  - pressed=0 and num is held for exactly 1 tick.
  - Then, if step<STEPS-1: step++ and return to PLAY.
  - Otherwise go to IDLE with busy=0, pressed=0, and done=1 for one cycle.
- Preemption:
  - In PLAY or GAP, if pending contains a bit j<active_id, abort at once and start melody j next cycle, exactly as from IDLE.
  - The preempted melody is dropped (no re-queue, no done pulse).
  - Equal- or lower-priority requests stay pending.
- Re-request of the active id while it plays: the pending bit is set, and the melody replays after completion.
- Back-to-back: on the IDLE cycle after done, pending is arbitrated normally. There is 1 IDLE cycle with pressed=0.
- Reset mid-melody: all state clears immediately and no done pulse is issued.
- Melody ROM, {note,rest,dur}:
  - 0 death: {3,0,4} {2,0,4} {1,0,4} {0,0,8}
  - 1 ghost: {0,0,2} {1,0,2} {0,0,2} {1,0,2}
  - 2 dot: {0,0,1} {0,1,1} {0,0,1} {0,1,1}
  - 3 start: {2,0,3} {2,0,3} {1,0,3} {0,0,6}

Decomposition:
- Package sound_pkg holds:
  - step_t struct: note[1:0], rest, dur[3:0].
  - Constant MELODY_ROM[4][4] of step_t.
  - state_t enum: IDLE, PLAY, GAP.
  - Requester-id localparams: SND_DEATH, SND_GHOST, SND_DOT, SND_START.
- Sub-module sound_tick_gen: prescaler with clk, rst, clear, and a tick output.

Test Plan (TICK_DIV=4):
1. Reset, then a single req=4'b0100 pulse.
   - busy=1 and active_id=2 after 2 edges.
   - pressed pattern 1,0,0,0,1,0,0,0 in 4-cycle tick units: note, gap, rest, gap repeated.
   - done pulses once and busy returns to 0.
2. req=4'b1010 in the same cycle.
   - Ghost (id1) plays first; start (id3) follows after 1 IDLE cycle.
   - Exactly two done pulses.
3. Start melody playing, then req[0] pulse at step 2.
   - Next cycle active_id=0, num=3, step restarted.
   - No done pulse for id3; id3 is not replayed.
4. Ghost playing, then req[2] pulse.
   - Ghost completes all 4 steps with num sequence 0,1,0,1.
   - Dot then starts.
5. Death melody mid step 1, then assert rst for 1 cycle.
   - Outputs go to 0 immediately (async).
   - pending=0, no done pulse; IDLE after release.
6. req[1] held high for 3 cycles while ghost is playing.
   - Ghost replays exactly once after the first completes.
   - Total 2 done pulses.
